pipelined_barrel_shifter: RTL and testbench

// - Parametrised, pipelined successor to the combinational 32-bit circular shifter.
// - Supports WIDTH-bit rotate, logical shift and arithmetic shift, either direction.
// - Uses a valid/ready handshake with full backpressure and a configurable pipeline depth.
// - Sits in the datapath between operand staging and the result bus; one op accepted per cycle.

---
 rtl/shift_pkg.sv | 29 ++
 rtl/shift_level.sv | 29 ++
 rtl/pipelined_barrel_shifter.sv | 164 ++++++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared mode type and mux-level-to-stage split helpers
package shift_pkg;

  typedef enum logic [1:0] {
    ROT = 2'b00,
    LSH = 2'b01,
    ASH = 2'b10,
    RSV = 2'b11
  } shift_mode_e;

  // First mux level handled by mux stage k; earlier stages absorb the remainder.
  function automatic int stage_first_level(input int k, input int nlev, input int nstg);
    int base;
    int extra;
    base  = nlev / nstg;
    extra = nlev % nstg;
    return k * base + ((k < extra) ? k : extra);
  endfunction

  function automatic int level_stage(input int j, input int nlev, input int nstg);
    int s;
    s = 0;
    for (int k = 1; k < nstg; k++) begin
      if (j >= stage_first_level(k, nlev, nstg)) s = k;
    end
    return s;
  endfunction

endpackage

// File: rtl/shift_level.sv
// rtl/shift_level.sv - one barrel mux level: optional rotate/shift by a fixed DIST
module shift_level
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic             dir,
  input  shift_mode_e      mode,
  input  logic             fill,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = data;
    if (en) begin
      if (mode == ROT || mode == RSV) begin
        result = dir ? {data[WIDTH-DIST-1:0], data[WIDTH-1:WIDTH-DIST]}
                     : {data[DIST-1:0], data[WIDTH-1:DIST]};
      end else begin
        result = dir ? {data[WIDTH-DIST-1:0], {DIST{1'b0}}}
                     : {{DIST{fill}}, data[WIDTH-1:DIST]};
      end
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - pipelined rotate/shift unit with valid/ready backpressure
module pipelined_barrel_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STAGES  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] shift_amt,
  input  logic               dir,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_zero
);

  localparam int LAST = STAGES;
  localparam logic [SHAMT_W:0] WIDTH_X = (SHAMT_W+1)'(WIDTH);

  // Register 0 holds the normalised op; register s (1..STAGES) follows mux stage s-1.
  logic [WIDTH-1:0]   data_q [STAGES+1];
  logic [WIDTH-1:0]   data_d [STAGES+1];
  logic [SHAMT_W-1:0] amt_q  [STAGES+1];
  logic [SHAMT_W-1:0] amt_d  [STAGES+1];
  logic               dir_q  [STAGES+1];
  logic               dir_d  [STAGES+1];
  shift_mode_e        mode_q [STAGES+1];
  shift_mode_e        mode_d [STAGES+1];
  logic [STAGES:0]    vld_q, vld_d, vld_in, adv;
  logic               zero_q, zero_d;

  logic [WIDTH-1:0]   nxt_data [STAGES+1];
  logic [SHAMT_W-1:0] nxt_amt  [STAGES+1];
  logic               nxt_dir  [STAGES+1];
  shift_mode_e        nxt_mode [STAGES+1];

  logic [STAGES-1:0][WIDTH-1:0] stage_res;

  shift_mode_e        in_mode;
  logic               in_over;
  logic [SHAMT_W-1:0] in_amt;
  logic [WIDTH-1:0]   in_pre;

  // Over-range counts are resolved here so every mux level sees a < WIDTH.
  always_comb begin
    in_mode = shift_mode_e'(mode);
    in_over = {1'b0, shift_amt} >= WIDTH_X;
    in_amt  = shift_amt;
    in_pre  = in_data;
    if (in_over) begin
      if (in_mode == ROT || in_mode == RSV) begin
        in_amt = SHAMT_W'({1'b0, shift_amt} - WIDTH_X);
      end else begin
        in_amt = '0;
        in_pre = (in_mode == ASH && !dir) ? {WIDTH{in_data[WIDTH-1]}} : '0;
      end
    end
  end

  for (genvar j = 0; j < SHAMT_W; j++) begin : g_lvl
    localparam int S = level_stage(j, SHAMT_W, STAGES);
    logic [WIDTH-1:0] lvl_in;
    logic [WIDTH-1:0] lvl_out;
    logic             fill;

    if (j == stage_first_level(S, SHAMT_W, STAGES)) begin : g_head
      assign lvl_in = data_q[S];
    end else begin : g_link
      assign lvl_in = g_lvl[j-1].lvl_out;
    end

    assign fill = (mode_q[S] == ASH) && !dir_q[S] && lvl_in[WIDTH-1];

    shift_level #(
      .WIDTH (WIDTH),
      .DIST  (2**j)
    ) u_level (
      .data   (lvl_in),
      .en     (amt_q[S][j]),
      .dir    (dir_q[S]),
      .mode   (mode_q[S]),
      .fill   (fill),
      .result (lvl_out)
    );

    if (j == stage_first_level(S+1, SHAMT_W, STAGES) - 1) begin : g_tail
      assign stage_res[S] = lvl_out;
    end
  end

  always_comb begin
    adv[LAST] = !vld_q[LAST] || out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      adv[k] = !vld_q[k] || adv[k+1];
    end
  end

  always_comb begin
    vld_in[0]   = in_valid;
    nxt_data[0] = in_pre;
    nxt_amt[0]  = in_amt;
    nxt_dir[0]  = dir;
    nxt_mode[0] = in_mode;
    for (int k = 1; k <= LAST; k++) begin
      vld_in[k]   = vld_q[k-1];
      nxt_data[k] = stage_res[k-1];
      nxt_amt[k]  = amt_q[k-1];
      nxt_dir[k]  = dir_q[k-1];
      nxt_mode[k] = mode_q[k-1];
    end
    zero_d = zero_q;
    for (int k = 0; k <= LAST; k++) begin
      vld_d[k]  = vld_q[k];
      data_d[k] = data_q[k];
      amt_d[k]  = amt_q[k];
      dir_d[k]  = dir_q[k];
      mode_d[k] = mode_q[k];
      if (adv[k]) begin
        vld_d[k] = vld_in[k];
        if (vld_in[k]) begin
          data_d[k] = nxt_data[k];
          amt_d[k]  = nxt_amt[k];
          dir_d[k]  = nxt_dir[k];
          mode_d[k] = nxt_mode[k];
        end
      end
    end
    if (adv[LAST] && vld_in[LAST]) zero_d = (nxt_data[LAST] == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      zero_q <= 1'b1;
      for (int k = 0; k <= LAST; k++) begin
        data_q[k] <= '0;
        amt_q[k]  <= '0;
        dir_q[k]  <= 1'b0;
        mode_q[k] <= ROT;
      end
    end else begin
      vld_q  <= vld_d;
      zero_q <= zero_d;
      for (int k = 0; k <= LAST; k++) begin
        data_q[k] <= data_d[k];
        amt_q[k]  <= amt_d[k];
        dir_q[k]  <= dir_d[k];
        mode_q[k] <= mode_d[k];
      end
    end
  end

  assign in_ready  = rst || adv[0];
  assign out_valid = vld_q[LAST];
  assign out_data  = data_q[LAST];
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb/tb_pipelined_barrel_shifter.sv - directed vector bench for the pipelined barrel shifter
module tb_pipelined_barrel_shifter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_dir, a_out_valid, a_out_ready, a_out_zero;
  logic [31:0] a_in_data, a_out_data;
  logic [4:0]  a_amt;
  logic [1:0]  a_mode;

  logic        b_in_valid, b_in_ready, b_dir, b_out_valid, b_out_ready, b_out_zero;
  logic [23:0] b_in_data, b_out_data;
  logic [4:0]  b_amt;
  logic [1:0]  b_mode;

  pipelined_barrel_shifter #(.WIDTH(32), .STAGES(2)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .shift_amt (a_amt),
    .dir       (a_dir),
    .mode      (a_mode),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .out_zero  (a_out_zero)
  );

  pipelined_barrel_shifter #(.WIDTH(24), .STAGES(3)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .shift_amt (b_amt),
    .dir       (b_dir),
    .mode      (b_mode),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .out_zero  (b_out_zero)
  );

  typedef struct {
    logic [31:0] din;
    logic [4:0]  amt;
    logic        dir;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec_t;

  vec_t va [17];
  vec_t vb [8];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_a(input vec_t v);
    a_in_valid = 1'b1;
    a_in_data  = v.din;
    a_amt      = v.amt;
    a_dir      = v.dir;
    a_mode     = v.mode;
  endtask

  task automatic run_a(input vec_t v, input string name, input bit chk_lat);
    int lat;
    drive_a(v);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    lat = 0;
    while (!a_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " valid"}, {31'b0, a_out_valid}, 32'd1);
    check({name, " data"}, a_out_data, v.exp);
    check({name, " zero"}, {31'b0, a_out_zero}, {31'b0, (v.exp == 32'h0)});
    if (chk_lat) check({name, " latency"}, lat, 32'd2);
    @(posedge clk); #1;
  endtask

  task automatic run_b(input vec_t v, input string name, input bit chk_lat);
    int lat;
    b_in_valid = 1'b1;
    b_in_data  = v.din[23:0];
    b_amt      = v.amt;
    b_dir      = v.dir;
    b_mode     = v.mode;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " valid"}, {31'b0, b_out_valid}, 32'd1);
    check({name, " data"}, {8'h0, b_out_data}, {8'h0, v.exp[23:0]});
    check({name, " zero"}, {31'b0, b_out_zero}, {31'b0, (v.exp[23:0] == 24'h0)});
    if (chk_lat) check({name, " latency"}, lat, 32'd3);
    @(posedge clk); #1;
  endtask

  task automatic backpressure();
    int sel [5];
    int sent;
    int got;
    int drop_at;
    int cyc;
    int extra;
    bit prev_stall;
    logic [31:0] prev_data;
    sel = '{0, 9, 10, 11, 14};
    sent = 0;
    got = 0;
    drop_at = -1;
    cyc = 0;
    extra = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    while (got < 5 && cyc < 40) begin
      a_out_ready = (cyc >= 4);
      if (sent < 5) drive_a(va[sel[sent]]);
      else a_in_valid = 1'b0;
      #1;
      if (prev_stall) check($sformatf("bp hold c%0d", cyc), a_out_data, prev_data);
      if (a_in_valid && !a_in_ready && drop_at < 0) drop_at = sent;
      if (a_out_valid && a_out_ready) begin
        check($sformatf("bp out%0d", got), a_out_data, va[sel[got]].exp);
        got++;
      end
      prev_stall = a_out_valid && !a_out_ready;
      prev_data  = a_out_data;
      if (a_in_valid && a_in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    check("bp accepted before stall", drop_at, 32'd3);
    check("bp result count", got, 32'd5);
    repeat (4) begin
      if (a_out_valid) extra++;
      @(posedge clk); #1;
    end
    check("bp duplicates", extra, 32'd0);
  endtask

  task automatic reset_midflight();
    int seen;
    seen = 0;
    a_out_ready = 1'b1;
    drive_a(va[0]);
    @(posedge clk); #1;
    drive_a(va[11]);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid rst out_valid", {31'b0, a_out_valid}, 32'd0);
    check("mid rst out_data", a_out_data, 32'h0);
    check("mid rst out_zero", {31'b0, a_out_zero}, 32'd1);
    repeat (6) begin
      if (a_out_valid) seen++;
      @(posedge clk); #1;
    end
    check("mid rst ghost ops", seen, 32'd0);
    run_a(va[15], "post rst", 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    va[0] = '{32'h8000_0001, 5'd4, 1'b1, 2'd0, 32'h0000_0018};
    for (int m = 0; m < 4; m++) begin
      for (int d = 0; d < 2; d++) begin
        va[1 + m*2 + d] = '{32'hDEAD_BEEF, 5'd0, 1'(d), 2'(m), 32'hDEAD_BEEF};
      end
    end
    va[9]  = '{32'hF000_0000, 5'd31, 1'b0, 2'd2, 32'hFFFF_FFFF};
    va[10] = '{32'hF000_0000, 5'd31, 1'b0, 2'd1, 32'h0000_0001};
    va[11] = '{32'h1234_5678, 5'd8,  1'b0, 2'd0, 32'h7812_3456};
    va[12] = '{32'h8000_0000, 5'd1,  1'b1, 2'd2, 32'h0000_0000};
    va[13] = '{32'h0000_00F0, 5'd24, 1'b1, 2'd1, 32'hF000_0000};
    va[14] = '{32'h8765_4321, 5'd16, 1'b1, 2'd3, 32'h4321_8765};
    va[15] = '{32'h7000_0000, 5'd4,  1'b0, 2'd2, 32'h0700_0000};
    va[16] = '{32'h8000_0000, 5'd1,  1'b0, 2'd2, 32'hC000_0000};

    vb[0] = '{32'h0000_0001, 5'd30, 1'b0, 2'd0, 32'h0004_0000};
    vb[1] = '{32'h0000_0001, 5'd30, 1'b0, 2'd1, 32'h0000_0000};
    vb[2] = '{32'h0080_0000, 5'd25, 1'b0, 2'd2, 32'h00FF_FFFF};
    vb[3] = '{32'h00AB_CDEF, 5'd24, 1'b1, 2'd0, 32'h00AB_CDEF};
    vb[4] = '{32'h00AB_CDEF, 5'd4,  1'b1, 2'd0, 32'h00BC_DEFA};
    vb[5] = '{32'h0000_0080, 5'd31, 1'b0, 2'd3, 32'h0000_0001};
    vb[6] = '{32'h007F_FFFF, 5'd24, 1'b0, 2'd2, 32'h0000_0000};
    vb[7] = '{32'h0080_0000, 5'd26, 1'b1, 2'd2, 32'h0000_0000};

    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_amt = '0; a_dir = 1'b0; a_mode = 2'd0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_amt = '0; b_dir = 1'b0; b_mode = 2'd0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", {31'b0, a_in_ready}, 32'd1);
    check("rst out_valid", {31'b0, a_out_valid}, 32'd0);
    check("rst out_data", a_out_data, 32'h0);
    check("rst out_zero", {31'b0, a_out_zero}, 32'd1);
    check("rst b out_valid", {31'b0, b_out_valid}, 32'd0);
    check("rst b out_zero", {31'b0, b_out_zero}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) run_a(va[i], $sformatf("a%0d", i), i == 0);
    for (int i = 0; i < 8; i++) run_b(vb[i], $sformatf("b%0d", i), i == 0);

    backpressure();
    reset_midflight();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
